// File: rtl/trigger_frame_builder.sv
// Self-triggered capture stage: opens a frame on a threshold hit, streams
// beats to the ADC FIFO and closes each frame with one HF FIFO word.
//
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   S_AXIS_TVALID/TDATA   RFDC beat stream, S_AXIS_TREADY low only in reset
//   THRESHOLD             signed trigger level, latched at trigger
//   ADC_FIFO_FULL/WR_EN/DIN  captured beat output
//   HF_FIFO_FULL/WR_EN/DIN   header+footer word output
//   TRIG_DROP_SAT         sticky drop-counter saturation flag
module trigger_frame_builder #(
  parameter int TDATA_WIDTH = 128,
  parameter int SAMPLE_WIDTH = 16,
  parameter int DATAFRAME_WIDTH = 64,
  parameter logic [7:0] HEADER_ID = 8'hAA,
  parameter logic [7:0] FOOTER_ID = 8'h55,
  parameter logic [7:0] CH_ID = 8'h00,
  parameter int MIN_BEATS = 2,
  parameter int MAX_BEATS = 64
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic S_AXIS_TVALID,
  input  logic [TDATA_WIDTH-1:0] S_AXIS_TDATA,
  output logic S_AXIS_TREADY,
  input  logic [SAMPLE_WIDTH-1:0] THRESHOLD,
  input  logic ADC_FIFO_FULL,
  output logic ADC_FIFO_WR_EN,
  output logic [TDATA_WIDTH-1:0] ADC_FIFO_DIN,
  input  logic HF_FIFO_FULL,
  output logic HF_FIFO_WR_EN,
  output logic [3*DATAFRAME_WIDTH-1:0] HF_FIFO_DIN,
  output logic TRIG_DROP_SAT
);

  localparam int NS = TDATA_WIDTH / SAMPLE_WIDTH;
  localparam int CW = 11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_FINALIZE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [47:0] r_ts, r_ts_lat;
  logic [15:0] r_seq, r_drops;
  logic [CW-1:0] r_count, w_cnt_inc;
  logic signed [SAMPLE_WIDTH-1:0] r_thr, r_max;
  logic r_trunc, r_maxlen, r_sat;
  logic r_adc_wr, r_hf_wr;
  logic [TDATA_WIDTH-1:0] r_adc_din;
  logic [3*DATAFRAME_WIDTH-1:0] r_hf_din;

  logic w_hit_live, w_hit_lat;
  logic signed [SAMPLE_WIDTH-1:0] w_beat_max;
  logic w_wr, w_trig, w_drop, w_trunc, w_maxlen;

  // Per-beat signed scan: hit against live and latched levels, beat max.
  always_comb begin : hit_scan
    logic signed [SAMPLE_WIDTH-1:0] v;
    w_hit_live = 1'b0;
    w_hit_lat = 1'b0;
    w_beat_max = S_AXIS_TDATA[SAMPLE_WIDTH-1:0];
    v = '0;
    for (int k = 0; k < NS; k++) begin
      v = S_AXIS_TDATA[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      if (v > $signed(THRESHOLD)) w_hit_live = 1'b1;
      if (v > r_thr) w_hit_lat = 1'b1;
      if (v > w_beat_max) w_beat_max = v;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr = 1'b0;
    w_trig = 1'b0;
    w_drop = 1'b0;
    w_trunc = 1'b0;
    w_maxlen = 1'b0;
    w_cnt_inc = r_count + 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (S_AXIS_TVALID && w_hit_live) begin
          if (!ADC_FIFO_FULL && !HF_FIFO_FULL) begin
            w_trig = 1'b1;
            w_wr = 1'b1;
            // The trigger beat is a hit, so only the length cap can close it.
            if (MAX_BEATS == 1) begin
              w_maxlen = 1'b1;
              w_state_nxt = S_FINALIZE;
            end else begin
              w_state_nxt = S_CAPTURE;
            end
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        if (S_AXIS_TVALID) begin
          if (ADC_FIFO_FULL) begin
            w_trunc = 1'b1;
            w_state_nxt = S_FINALIZE;
          end else begin
            w_wr = 1'b1;
            if (w_cnt_inc == CW'(MAX_BEATS)) begin
              w_maxlen = 1'b1;
              w_state_nxt = S_FINALIZE;
            end else if (!w_hit_lat &&
                         w_cnt_inc >= CW'(MIN_BEATS)) begin
              w_state_nxt = S_FINALIZE;
            end
          end
        end
      end
      S_FINALIZE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= S_IDLE;
      r_ts <= '0;
      r_ts_lat <= '0;
      r_seq <= '0;
      r_drops <= '0;
      r_count <= '0;
      r_thr <= '0;
      r_max <= '0;
      r_trunc <= 1'b0;
      r_maxlen <= 1'b0;
      r_sat <= 1'b0;
      r_adc_wr <= 1'b0;
      r_hf_wr <= 1'b0;
      r_adc_din <= '1;
      r_hf_din <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_ts <= r_ts + 48'd1;
      r_adc_wr <= w_wr;
      if (w_wr) r_adc_din <= S_AXIS_TDATA;
      if (w_trig) begin
        r_thr <= $signed(THRESHOLD);
        r_ts_lat <= r_ts;
        r_count <= CW'(1);
        r_max <= w_beat_max;
        r_trunc <= 1'b0;
        r_maxlen <= 1'b0;
      end else if (w_wr) begin
        r_count <= w_cnt_inc;
        if (w_beat_max > r_max) r_max <= w_beat_max;
      end
      if (w_trunc) r_trunc <= 1'b1;
      if (w_maxlen) r_maxlen <= 1'b1;
      r_hf_wr <= (r_state == S_FINALIZE);
      if (r_state == S_FINALIZE) begin
        r_hf_din <= {HEADER_ID, CH_ID, r_count, 1'b0, 4'h0,
                     r_ts_lat[47:16],
                     r_ts_lat[15:0], r_thr, 32'h0,
                     FOOTER_ID, r_seq, r_max, r_drops,
                     6'h0, r_maxlen, r_trunc};
        r_seq <= r_seq + 16'd1;
        r_drops <= '0;
      end else if (w_drop && r_drops != 16'hFFFF) begin
        r_drops <= r_drops + 16'd1;
        if (r_drops == 16'hFFFE) r_sat <= 1'b1;
      end
    end
  end

  assign S_AXIS_TREADY = ~ARESET;
  assign ADC_FIFO_WR_EN = r_adc_wr;
  assign ADC_FIFO_DIN = r_adc_din;
  assign HF_FIFO_WR_EN = r_hf_wr;
  assign HF_FIFO_DIN = r_hf_din;
  assign TRIG_DROP_SAT = r_sat;

endmodule

// File: tb/tb_trigger_frame_builder.sv
// Directed bench for trigger_frame_builder.
// Beats are driven on the falling edge, outputs logged on the falling edge.
module tb_trigger_frame_builder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ARESET;
  logic S_AXIS_TVALID;
  logic [127:0] S_AXIS_TDATA;
  logic S_AXIS_TREADY;
  logic [15:0] THRESHOLD;
  logic ADC_FIFO_FULL;
  logic ADC_FIFO_WR_EN;
  logic [127:0] ADC_FIFO_DIN;
  logic HF_FIFO_FULL;
  logic HF_FIFO_WR_EN;
  logic [191:0] HF_FIFO_DIN;
  logic TRIG_DROP_SAT;

  trigger_frame_builder dut (
    .ACLK(clk),
    .ARESET(ARESET),
    .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TDATA(S_AXIS_TDATA),
    .S_AXIS_TREADY(S_AXIS_TREADY),
    .THRESHOLD(THRESHOLD),
    .ADC_FIFO_FULL(ADC_FIFO_FULL),
    .ADC_FIFO_WR_EN(ADC_FIFO_WR_EN),
    .ADC_FIFO_DIN(ADC_FIFO_DIN),
    .HF_FIFO_FULL(HF_FIFO_FULL),
    .HF_FIFO_WR_EN(HF_FIFO_WR_EN),
    .HF_FIFO_DIN(HF_FIFO_DIN),
    .TRIG_DROP_SAT(TRIG_DROP_SAT)
  );

  int errors = 0;
  int checks = 0;

  // Cycle counter; same reset and step as the timestamp.
  logic [47:0] cyc = '0;
  always @(posedge clk) begin
    if (ARESET) cyc <= '0;
    else cyc <= cyc + 48'd1;
  end

  int adc_cnt = 0;
  logic [47:0] adc_rise_cyc = '0;
  logic [47:0] adc_last_cyc = '0;
  logic [127:0] adc_last_din = '0;
  logic prev_wr = 1'b0;
  logic [191:0] hf_q[$];
  logic [47:0] hf_cyc_q[$];

  always @(negedge clk) begin
    if (ADC_FIFO_WR_EN === 1'b1) begin
      adc_cnt <= adc_cnt + 1;
      adc_last_cyc <= cyc;
      adc_last_din <= ADC_FIFO_DIN;
      if (!prev_wr) adc_rise_cyc <= cyc;
    end
    prev_wr <= (ADC_FIFO_WR_EN === 1'b1);
    if (HF_FIFO_WR_EN === 1'b1) begin
      hf_q.push_back(HF_FIFO_DIN);
      hf_cyc_q.push_back(cyc);
    end
  end

  // Sample 7 is -30000 in every beat: an unsigned compare would hit on it.
  function automatic logic [127:0] mk(input logic [15:0] s3,
                                      input logic [15:0] s0);
    logic [127:0] d;
    d = '0;
    d[127:112] = 16'h8AD0;
    d[63:48] = s3;
    d[15:0] = s0;
    return d;
  endfunction

  logic [127:0] quiet;
  assign quiet = mk(16'd0, 16'd7);

  task automatic beat(input logic v, input logic [127:0] d);
    @(negedge clk);
    S_AXIS_TVALID = v;
    S_AXIS_TDATA = d;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 128'h0);
  endtask

  task automatic test_reset;
    ARESET = 1'b1;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TDATA = '0;
    THRESHOLD = 16'd100;
    ADC_FIFO_FULL = 1'b0;
    HF_FIFO_FULL = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ADC_FIFO_WR_EN !== 1'b0) begin
      errors++;
      $display("FAIL reset_adc_wr got=%b want=0", ADC_FIFO_WR_EN);
    end
    checks++;
    if (HF_FIFO_WR_EN !== 1'b0) begin
      errors++;
      $display("FAIL reset_hf_wr got=%b want=0", HF_FIFO_WR_EN);
    end
    checks++;
    if (ADC_FIFO_DIN !== {128{1'b1}}) begin
      errors++;
      $display("FAIL reset_adc_din got=%h", ADC_FIFO_DIN);
    end
    checks++;
    if (HF_FIFO_DIN !== {192{1'b1}}) begin
      errors++;
      $display("FAIL reset_hf_din got=%h", HF_FIFO_DIN);
    end
    checks++;
    if (S_AXIS_TREADY !== 1'b0 || TRIG_DROP_SAT !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy_sat got=%b%b want=00",
               S_AXIS_TREADY, TRIG_DROP_SAT);
    end
    ARESET = 1'b0;
    idle(2);
    checks++;
    if (S_AXIS_TREADY !== 1'b1) begin
      errors++;
      $display("FAIL ready_after got=%b want=1", S_AXIS_TREADY);
    end
  endtask

  task automatic test_basic_frame;
    int a0;
    int h0;
    logic [47:0] c0;
    logic [191:0] exp;
    a0 = adc_cnt;
    h0 = hf_q.size();
    beat(1'b1, quiet);
    beat(1'b1, mk(16'd500, 16'd1));
    c0 = cyc;
    beat(1'b1, mk(16'd500, 16'd2));
    beat(1'b1, mk(16'd500, 16'd3));
    repeat (4) beat(1'b1, quiet);
    idle(3);
    checks++;
    if (adc_cnt - a0 !== 4) begin
      errors++;
      $display("FAIL basic_writes got=%0d want=4", adc_cnt - a0);
    end
    checks++;
    if (adc_rise_cyc !== c0 + 48'd1) begin
      errors++;
      $display("FAIL basic_latency got=%0d want=%0d",
               adc_rise_cyc, c0 + 48'd1);
    end
    checks++;
    if (adc_last_din !== quiet) begin
      errors++;
      $display("FAIL basic_tail_din got=%h want=%h", adc_last_din, quiet);
    end
    checks++;
    if (hf_q.size() - h0 !== 1 || hf_cyc_q[h0] !== c0 + 48'd5) begin
      errors++;
      $display("FAIL basic_hf_time got n=%0d cyc=%0d want n=1 cyc=%0d",
               hf_q.size() - h0, hf_cyc_q[h0], c0 + 48'd5);
    end
    exp = {8'hAA, 8'h00, 12'd8, 4'h0, c0[47:16],
           c0[15:0], 16'd100, 32'h0,
           8'h55, 16'd0, 16'd500, 16'd0, 8'h00};
    checks++;
    if (hf_q[h0] !== exp) begin
      errors++;
      $display("FAIL basic_hf got=%h want=%h", hf_q[h0], exp);
    end
  endtask

  task automatic test_min_len;
    int a0;
    int h0;
    logic [47:0] c0;
    logic [191:0] exp;
    a0 = adc_cnt;
    h0 = hf_q.size();
    beat(1'b1, mk(16'd300, 16'd2));
    c0 = cyc;
    repeat (3) beat(1'b1, quiet);
    idle(3);
    checks++;
    if (adc_cnt - a0 !== 2) begin
      errors++;
      $display("FAIL min_writes got=%0d want=2", adc_cnt - a0);
    end
    exp = {8'hAA, 8'h00, 12'd4, 4'h0, c0[47:16],
           c0[15:0], 16'd100, 32'h0,
           8'h55, 16'd1, 16'd300, 16'd0, 8'h00};
    checks++;
    if (hf_q[h0] !== exp) begin
      errors++;
      $display("FAIL min_hf got=%h want=%h", hf_q[h0], exp);
    end
  endtask

  task automatic test_max_len;
    int a0;
    int h0;
    logic [47:0] c0;
    logic [47:0] c1;
    logic [191:0] exp;
    a0 = adc_cnt;
    h0 = hf_q.size();
    c0 = '0;
    for (int i = 0; i < 70; i++) begin
      beat(1'b1, mk(16'(200 + i), 16'(i)));
      if (i == 0) c0 = cyc;
    end
    repeat (3) beat(1'b1, quiet);
    idle(3);
    c1 = c0 + 48'd65;
    checks++;
    if (adc_cnt - a0 !== 70) begin
      errors++;
      $display("FAIL max_writes got=%0d want=70", adc_cnt - a0);
    end
    checks++;
    if (hf_q.size() - h0 !== 2 || hf_cyc_q[h0] !== c1) begin
      errors++;
      $display("FAIL max_hf_time got n=%0d cyc=%0d want n=2 cyc=%0d",
               hf_q.size() - h0, hf_cyc_q[h0], c1);
    end
    exp = {8'hAA, 8'h00, 12'd128, 4'h0, c0[47:16],
           c0[15:0], 16'd100, 32'h0,
           8'h55, 16'd2, 16'd263, 16'd0, 8'h02};
    checks++;
    if (hf_q[h0] !== exp) begin
      errors++;
      $display("FAIL max_hf got=%h want=%h", hf_q[h0], exp);
    end
    exp = {8'hAA, 8'h00, 12'd12, 4'h0, c1[47:16],
           c1[15:0], 16'd100, 32'h0,
           8'h55, 16'd3, 16'd269, 16'd0, 8'h00};
    checks++;
    if (hf_q[h0+1] !== exp) begin
      errors++;
      $display("FAIL max_next_hf got=%h want=%h", hf_q[h0+1], exp);
    end
  endtask

  task automatic test_truncate;
    int a0;
    int h0;
    logic [47:0] c0;
    logic [47:0] tr;
    logic [191:0] exp;
    a0 = adc_cnt;
    h0 = hf_q.size();
    c0 = '0;
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, mk(16'd400, 16'(i)));
      if (i == 0) c0 = cyc;
    end
    beat(1'b1, mk(16'd400, 16'd5));
    ADC_FIFO_FULL = 1'b1;
    tr = cyc;
    beat(1'b1, mk(16'd400, 16'd6));
    beat(1'b0, 128'h0);
    ADC_FIFO_FULL = 1'b0;
    idle(3);
    checks++;
    if (adc_cnt - a0 !== 5) begin
      errors++;
      $display("FAIL trunc_writes got=%0d want=5", adc_cnt - a0);
    end
    checks++;
    if (hf_q.size() - h0 !== 1 || hf_cyc_q[h0] !== tr + 48'd2) begin
      errors++;
      $display("FAIL trunc_hf_time got n=%0d cyc=%0d want n=1 cyc=%0d",
               hf_q.size() - h0, hf_cyc_q[h0], tr + 48'd2);
    end
    exp = {8'hAA, 8'h00, 12'd10, 4'h0, c0[47:16],
           c0[15:0], 16'd100, 32'h0,
           8'h55, 16'd4, 16'd400, 16'd0, 8'h01};
    checks++;
    if (hf_q[h0] !== exp) begin
      errors++;
      $display("FAIL trunc_hf got=%h want=%h", hf_q[h0], exp);
    end
  endtask

  task automatic test_hf_full_drops;
    int a0;
    int h0;
    logic [47:0] c0;
    logic [191:0] exp;
    a0 = adc_cnt;
    h0 = hf_q.size();
    HF_FIFO_FULL = 1'b1;
    repeat (3) beat(1'b1, mk(16'd600, 16'd0));
    beat(1'b0, 128'h0);
    HF_FIFO_FULL = 1'b0;
    idle(2);
    checks++;
    if (adc_cnt !== a0 || hf_q.size() !== h0) begin
      errors++;
      $display("FAIL drop_no_write got adc=%0d hf=%0d want 0 0",
               adc_cnt - a0, hf_q.size() - h0);
    end
    beat(1'b1, mk(16'd600, 16'd1));
    c0 = cyc;
    repeat (3) beat(1'b1, quiet);
    idle(3);
    exp = {8'hAA, 8'h00, 12'd4, 4'h0, c0[47:16],
           c0[15:0], 16'd100, 32'h0,
           8'h55, 16'd5, 16'd600, 16'd3, 8'h00};
    checks++;
    if (hf_q[h0] !== exp) begin
      errors++;
      $display("FAIL drop_hf got=%h want=%h", hf_q[h0], exp);
    end
    checks++;
    if (TRIG_DROP_SAT !== 1'b0) begin
      errors++;
      $display("FAIL drop_sat_early got=%b want=0", TRIG_DROP_SAT);
    end
  endtask

  task automatic test_drop_sat;
    int a0;
    int h0;
    a0 = adc_cnt;
    h0 = hf_q.size();
    HF_FIFO_FULL = 1'b1;
    repeat (65536) beat(1'b1, mk(16'd700, 16'd0));
    beat(1'b0, 128'h0);
    HF_FIFO_FULL = 1'b0;
    idle(2);
    checks++;
    if (TRIG_DROP_SAT !== 1'b1 || adc_cnt !== a0) begin
      errors++;
      $display("FAIL sat_flag got sat=%b adc=%0d want sat=1 adc=0",
               TRIG_DROP_SAT, adc_cnt - a0);
    end
    beat(1'b1, mk(16'd700, 16'd1));
    repeat (3) beat(1'b1, quiet);
    beat(1'b1, mk(16'd800, 16'd1));
    repeat (3) beat(1'b1, quiet);
    idle(3);
    checks++;
    if (hf_q[h0][63:8] !== {8'h55, 16'd6, 16'd700, 16'hFFFF}) begin
      errors++;
      $display("FAIL sat_footer got=%h want=55_0006_02bc_ffff",
               hf_q[h0][63:8]);
    end
    checks++;
    if (hf_q[h0+1][63:8] !== {8'h55, 16'd7, 16'd800, 16'h0000}) begin
      errors++;
      $display("FAIL sat_clear got=%h want=55_0007_0320_0000",
               hf_q[h0+1][63:8]);
    end
    checks++;
    if (TRIG_DROP_SAT !== 1'b1) begin
      errors++;
      $display("FAIL sat_sticky got=%b want=1", TRIG_DROP_SAT);
    end
  endtask

  task automatic test_reset_mid;
    int h0;
    logic [191:0] exp;
    repeat (3) beat(1'b1, mk(16'd900, 16'd0));
    h0 = hf_q.size();
    beat(1'b1, mk(16'd900, 16'd1));
    ARESET = 1'b1;
    @(negedge clk);
    checks++;
    if (ADC_FIFO_WR_EN !== 1'b0 || HF_FIFO_WR_EN !== 1'b0 ||
        S_AXIS_TREADY !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_ctl got=%b%b%b want=000",
               ADC_FIFO_WR_EN, HF_FIFO_WR_EN, S_AXIS_TREADY);
    end
    checks++;
    if (ADC_FIFO_DIN !== {128{1'b1}} || HF_FIFO_DIN !== {192{1'b1}} ||
        TRIG_DROP_SAT !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_data got adc=%h hf=%h sat=%b",
               ADC_FIFO_DIN, HF_FIFO_DIN, TRIG_DROP_SAT);
    end
    // Released in the same cycle as a hit: it sees ts=0.
    ARESET = 1'b0;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA = mk(16'd250, 16'd0);
    repeat (3) beat(1'b1, quiet);
    idle(3);
    checks++;
    if (hf_q.size() - h0 !== 1) begin
      errors++;
      $display("FAIL mid_hf_count got=%0d want=1", hf_q.size() - h0);
    end
    exp = {8'hAA, 8'h00, 12'd4, 4'h0, 32'h0,
           16'h0, 16'd100, 32'h0,
           8'h55, 16'd0, 16'd250, 16'd0, 8'h00};
    checks++;
    if (hf_q[h0] !== exp) begin
      errors++;
      $display("FAIL mid_after_hf got=%h want=%h", hf_q[h0], exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_min_len();
    test_max_len();
    test_truncate();
    test_hf_full_drops();
    test_drop_sat();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
